// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between a CPU port and a
// DMA/program-loader port. It serializes accesses, drives the memory strobes,
// waits out the fixed read latency and returns per-port read data plus a
// one-cycle completion ack. The CPU has priority. A starvation counter forces
// a DMA win after STARVE_MAX consecutive CPU wins over a pending DMA request.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   cpu_req/we/addr/wdata            CPU request (req held until cpu_ack)
//   cpu_ack, cpu_rdata               CPU completion pulse, held read data
//   dma_req/we/addr/wdata            DMA request (req held until dma_ack)
//   dma_ack, dma_rdata               DMA completion pulse, held read data
//   mem_re, mem_we                   memory read / write strobes
//   mem_addr, mem_wdata, mem_rdata   memory address, write data, read data
//   busy                             high whenever not IDLE
//   owner                            0 = CPU, 1 = DMA (current/last txn)
module mem_port_arbiter #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] lat_cnt, lat_cnt_d;
    logic [CW-1:0] starve_cnt, starve_cnt_d;
    logic          txn_we, txn_we_d;
    logic          dma_win;

    logic          mem_re_d, mem_we_d, cpu_ack_d, dma_ack_d, busy_d, owner_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, cpu_rdata_d, dma_rdata_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            txn_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_d;
            lat_cnt    <= lat_cnt_d;
            starve_cnt <= starve_cnt_d;
            txn_we     <= txn_we_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            cpu_ack    <= cpu_ack_d;
            dma_ack    <= dma_ack_d;
            busy       <= busy_d;
            owner      <= owner_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_rdata  <= cpu_rdata_d;
            dma_rdata  <= dma_rdata_d;
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_d      = state;
        lat_cnt_d    = lat_cnt;
        starve_cnt_d = starve_cnt;
        txn_we_d     = txn_we;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        owner_d      = owner;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_rdata_d  = cpu_rdata;
        dma_rdata_d  = dma_rdata;
        dma_win      = dma_req && (!cpu_req || (starve_cnt == CW'(STARVE_MAX)));

        unique case (state)
            IDLE: begin
                // A CPU win over a pending DMA implies starve_cnt < STARVE_MAX,
                // so the increment never passes the saturation value.
                if (cpu_req && dma_req && !dma_win) begin
                    starve_cnt_d = starve_cnt + CW'(1);
                end else begin
                    starve_cnt_d = '0;
                end
                if (cpu_req || dma_req) begin
                    state_d     = ISSUE;
                    owner_d     = dma_win;
                    txn_we_d    = dma_win ? dma_we    : cpu_we;
                    mem_addr_d  = dma_win ? dma_addr  : cpu_addr;
                    mem_wdata_d = dma_win ? dma_wdata : cpu_wdata;
                    // Strobe is registered, so it is high during ISSUE
                    mem_re_d    = !txn_we_d;
                    mem_we_d    = txn_we_d;
                end
            end
            ISSUE: begin
                lat_cnt_d = CW'(MEM_LAT);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == CW'(1)) begin
                    state_d = ACK;
                    if (!txn_we) begin
                        if (owner) begin
                            dma_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    if (owner) begin
                        dma_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt - CW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A transaction
// timeline model predicts every output each cycle for the MEM_LAT=1 instance;
// a second instance with MEM_LAT=3 is checked against literal expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 16;
    localparam int unsigned LAT  = 1;
    localparam int unsigned SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_re, mem_we, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_pipe = 16'hDEAD;

    logic          l3_cpu_req, l3_cpu_we, l3_cpu_ack;
    logic [AW-1:0] l3_cpu_addr;
    logic [DW-1:0] l3_cpu_wdata, l3_cpu_rdata;
    logic          l3_dma_req, l3_dma_we, l3_dma_ack;
    logic [AW-1:0] l3_dma_addr;
    logic [DW-1:0] l3_dma_wdata, l3_dma_rdata;
    logic          l3_mem_re, l3_mem_we, l3_busy, l3_owner;
    logic [AW-1:0] l3_mem_addr;
    logic [DW-1:0] l3_mem_wdata;
    logic [DW-1:0] p3_0 = 16'hDEAD, p3_1 = 16'hDEAD, p3_2 = 16'hDEAD;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rd_pipe), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut_l3 (
        .clk(clk), .reset(reset),
        .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
        .cpu_ack(l3_cpu_ack), .cpu_rdata(l3_cpu_rdata),
        .dma_req(l3_dma_req), .dma_we(l3_dma_we), .dma_addr(l3_dma_addr), .dma_wdata(l3_dma_wdata),
        .dma_ack(l3_dma_ack), .dma_rdata(l3_dma_rdata),
        .mem_re(l3_mem_re), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(p3_2), .busy(l3_busy), .owner(l3_owner)
    );

    // Power-on memory contents
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    // Memory responder, MEM_LAT=1: data appears the cycle after mem_re
    bit          mv [0:4095];
    logic [15:0] md [0:4095];
    always @(posedge clk) begin
        if (mem_we) begin
            mv[mem_addr[11:0]] <= 1'b1;
            md[mem_addr[11:0]] <= mem_wdata;
        end
        rd_pipe <= !mem_re ? 16'hDEAD :
                   (mv[mem_addr[11:0]] ? md[mem_addr[11:0]] : init_val(mem_addr));
    end

    // Memory responder, MEM_LAT=3 (read-only)
    always @(posedge clk) begin
        p3_0 <= l3_mem_re ? init_val(l3_mem_addr) : 16'hDEAD;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end

    // Transaction timeline model: at each idle sampling edge it schedules the
    // strobe cycle, the busy window and the ack cycle of the winner.
    int          cyc = 0;
    int          free_at = 0;
    int          tr_issue = -100;
    int          tr_ack = -100;
    int          starve = 0;
    bit          tr_we = 1'b1;
    bit          m_owner = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, tr_rd = '0;
    logic [15:0] exp_cpu_rdata = '0, exp_dma_rdata = '0;
    bit          ref_v [0:4095];
    logic [15:0] ref_d [0:4095];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            free_at = 0; tr_issue = -100; tr_ack = -100; starve = 0;
            m_owner = 1'b0; m_addr = '0; m_wdata = '0;
            exp_cpu_rdata = '0; exp_dma_rdata = '0;
        end else begin
            if (cyc >= free_at) begin
                if (cpu_req || dma_req) begin
                    bit dw;
                    dw = dma_req && (!cpu_req || starve == int'(SMAX));
                    if (!dw && dma_req) starve = (starve + 1 > int'(SMAX)) ? int'(SMAX) : starve + 1;
                    else starve = 0;
                    m_owner  = dw;
                    tr_we    = dw ? dma_we : cpu_we;
                    m_addr   = dw ? dma_addr : cpu_addr;
                    m_wdata  = dw ? dma_wdata : cpu_wdata;
                    tr_issue = cyc + 1;
                    tr_ack   = cyc + 2 + int'(LAT);
                    free_at  = cyc + 3 + int'(LAT);
                    if (tr_we) begin
                        ref_v[m_addr[11:0]] = 1'b1;
                        ref_d[m_addr[11:0]] = m_wdata;
                    end else begin
                        tr_rd = ref_v[m_addr[11:0]] ? ref_d[m_addr[11:0]] : init_val(m_addr);
                    end
                end else begin
                    starve = 0;
                end
            end
            cyc++;
            if (cyc == tr_ack && !tr_we) begin
                if (m_owner) exp_dma_rdata = tr_rd;
                else         exp_cpu_rdata = tr_rd;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("mem_re",    32'(mem_re),   32'((cyc == tr_issue) && !tr_we));
        chk("mem_we",    32'(mem_we),   32'((cyc == tr_issue) && tr_we));
        chk("busy",      32'(busy),     32'((cyc >= tr_issue) && (cyc <= tr_ack)));
        chk("cpu_ack",   32'(cpu_ack),  32'((cyc == tr_ack) && !m_owner));
        chk("dma_ack",   32'(dma_ack),  32'((cyc == tr_ack) && m_owner));
        chk("owner",     32'(owner),    32'(m_owner));
        chk("mem_addr",  32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        chk("dma_rdata", 32'(dma_rdata), 32'(exp_dma_rdata));
        chk("strobe_excl", 32'(mem_re & mem_we), 32'(0));
    endtask

    // All time advances through here, so every cycle is compared
    task automatic tick();
        @(negedge clk);
        compare_model();
    endtask

    // Issue one request at the current negedge (DUT idle); returns cycle
    // offsets of strobe and ack relative to the sampling cycle.
    task automatic txn(input bit dma, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input bit drop_early,
                       output int ack_k, output int strobe_k,
                       output logic [15:0] s_addr, output logic [15:0] s_wdata);
        ack_k = -1; strobe_k = -1; s_addr = '0; s_wdata = '0;
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        for (int k = 1; k <= 20 && ack_k < 0; k++) begin
            tick();
            if ((mem_re || mem_we) && strobe_k < 0) begin
                strobe_k = k; s_addr = mem_addr; s_wdata = mem_wdata;
            end
            if (dma ? dma_ack : cpu_ack) begin
                ack_k = k;
                if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
            end
            if (drop_early && k == 1) begin
                cpu_req  = 1'b0;
                cpu_addr = a + 16'h0010;
            end
        end
    endtask

    initial begin
        int          ak, sk, n_cpu, first, acks, l3a, l3r, l3b;
        bit          got_dma;
        logic [15:0] sa, sw, l3d;

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        l3_cpu_req = 0; l3_cpu_we = 0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
        l3_dma_req = 0; l3_dma_we = 0; l3_dma_addr = '0; l3_dma_wdata = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        reset = 1'b0;
        tick();

        // CPU read of 0x0010, memory returns BEEF
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, ak, sk, sa, sw);
        chk("t1_ack_lat", 32'(ak), 3);
        chk("t1_strobe_lat", 32'(sk), 1);
        chk("t1_addr", 32'(sa), 32'h0010);
        chk("t1_rdata", 32'(cpu_rdata), 32'hBEEF);
        tick();

        // DMA write 0x0100 <= 1234
        txn(1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, ak, sk, sa, sw);
        chk("t2_ack_lat", 32'(ak), 3);
        chk("t2_addr", 32'(sa), 32'h0100);
        chk("t2_wdata", 32'(sw), 32'h1234);
        chk("t2_owner", 32'(owner), 1);
        chk("t2_cpu_rdata_kept", 32'(cpu_rdata), 32'hBEEF);
        tick();

        // DMA read back
        txn(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, ak, sk, sa, sw);
        chk("t3_dma_rdata", 32'(dma_rdata), 32'h1234);
        tick();

        // Simultaneous requests, CPU held: four CPU wins, then the DMA
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 16'h55AA;
        n_cpu = 0; first = -1; got_dma = 1'b0;
        for (int k = 0; k < 60 && !got_dma; k++) begin
            tick();
            if (cpu_ack) begin
                n_cpu++;
                if (first < 0) first = 0;
            end
            if (dma_ack) begin
                got_dma = 1'b1;
                if (first < 0) first = 1;
                cpu_req = 0; dma_req = 0;
            end
        end
        chk("t4_first_is_cpu", 32'(first), 0);
        chk("t4_cpu_before_dma", 32'(n_cpu), 4);
        chk("t4_dma_acked", 32'(got_dma), 1);
        tick();

        // Reset asserted in WAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        tick();
        tick();
        chk("t5_busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        cpu_req = 0;
        #1;
        chk("t5_rst_mem_re", 32'(mem_re), 0);
        chk("t5_rst_cpu_ack", 32'(cpu_ack), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("t5_rst_dma_rdata", 32'(dma_rdata), 0);
        chk("t5_rst_mem_addr", 32'(mem_addr), 0);
        chk("t5_rst_owner", 32'(owner), 0);
        tick();
        tick();
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_ack || dma_ack) acks++;
        end
        chk("t5_no_ack_after_rst", 32'(acks), 0);
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, ak, sk, sa, sw);
        chk("t5_next_ack_lat", 32'(ak), 3);
        chk("t5_next_rdata", 32'(cpu_rdata), 32'hA583);
        tick();

        // Request dropped and address changed right after sampling
        txn(1'b0, 1'b0, 16'h0050, 16'h0000, 1'b1, ak, sk, sa, sw);
        chk("t6_ack_lat", 32'(ak), 3);
        chk("t6_addr", 32'(sa), 32'h0050);
        chk("t6_rdata", 32'(cpu_rdata), 32'hA593);
        tick();

        // CPU write then read back
        txn(1'b0, 1'b1, 16'h0070, 16'hCAFE, 1'b0, ak, sk, sa, sw);
        chk("t7_wdata", 32'(sw), 32'hCAFE);
        tick();
        txn(1'b0, 1'b0, 16'h0070, 16'h0000, 1'b0, ak, sk, sa, sw);
        chk("t7_rdata", 32'(cpu_rdata), 32'hCAFE);
        tick();

        // MEM_LAT=3 instance: CPU read of 0x0020
        l3_cpu_req = 1; l3_cpu_we = 0; l3_cpu_addr = 16'h0020;
        l3a = -1; l3r = -1; l3b = 0; l3d = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (l3_busy) l3b++;
            if (l3_mem_re && l3r < 0) l3r = k;
            if (l3_dma_ack) l3a = -2;
            if (l3_cpu_ack && l3a == -1) begin
                l3a = k;
                l3d = l3_cpu_rdata;
                l3_cpu_req = 0;
            end
        end
        chk("t8_ack_lat", 32'(l3a), 5);
        chk("t8_strobe_lat", 32'(l3r), 1);
        chk("t8_busy_cycles", 32'(l3b), 5);
        chk("t8_rdata", 32'(l3d), 32'hA5E3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
